fetch_decode_queue: RTL and testbench

//   Instruction queue between instruction fetch and decode. Buffers {pc, instr} pairs
//   and decouples fetch from decode with valid/ready handshakes on both sides.

---
 rtl/fetch_decode_queue.sv | 84 ++++++++
 tb/tb_fetch_decode_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue.
// Circular buffer of {pc, instr} with flush and illegal-encoding flag.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       if_valid_i,
  input  logic [XLEN-1:0]            if_pc_i,
  input  logic [ILEN-1:0]            if_instr_i,
  output logic                       if_ready_o,
  output logic                       id_valid_o,
  output logic [XLEN-1:0]            id_pc_o,
  output logic [ILEN-1:0]            id_instr_o,
  output logic                       id_illegal_o,
  input  logic                       id_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  entry_t        head;

  assign if_ready_o = (count != CW'(DEPTH));
  assign id_valid_o = (count != '0);

  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = id_valid_o & id_ready_i & ~flush_i;

  assign head = mem[rd_ptr];

  // Zero is the bubble encoding, so mask everything when empty.
  always_comb begin
    id_pc_o      = '0;
    id_instr_o   = '0;
    id_illegal_o = 1'b0;
    if (id_valid_o) begin
      id_pc_o      = head.pc;
      id_instr_o   = head.instr;
      id_illegal_o = (head.instr[1:0] != 2'b11);
    end
  end

  assign count_o = count;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; only pointers and count are.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= '{pc: if_pc_i, instr: if_instr_i};
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue.
// Linear steps with immediate assertions at each check.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [63:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic        if_ready;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_illegal;
  logic        id_ready = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(4), .XLEN(64), .ILEN(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .if_valid_i   (if_valid),
    .if_pc_i      (if_pc),
    .if_instr_i   (if_instr),
    .if_ready_o   (if_ready),
    .id_valid_o   (id_valid),
    .id_pc_o      (id_pc),
    .id_instr_o   (id_instr),
    .id_illegal_o (id_illegal),
    .id_ready_i   (id_ready),
    .count_o      (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".count"}, 64'(count), 64'd0);
    chk({tag, ".if_ready"}, 64'(if_ready), 64'd1);
    chk({tag, ".id_valid"}, 64'(id_valid), 64'd0);
    chk({tag, ".pc"}, id_pc, 64'd0);
    chk({tag, ".instr"}, 64'(id_instr), 64'd0);
    chk({tag, ".illegal"}, 64'(id_illegal), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("reset");

    // single push
    if_valid = 1'b1;
    if_pc    = 64'h1000;
    if_instr = 32'h00500093;
    step();
    if_valid = 1'b0;
    chk("t1.valid", 64'(id_valid), 64'd1);
    chk("t1.pc", id_pc, 64'h1000);
    chk("t1.instr", 64'(id_instr), 64'h00500093);
    chk("t1.illegal", 64'(id_illegal), 64'd0);
    chk("t1.count", 64'(count), 64'd1);
    id_ready = 1'b1;
    step();
    chk("t1.pop_count", 64'(count), 64'd0);
    step();
    chk("empty_pop.count", 64'(count), 64'd0);
    chk("empty_pop.valid", 64'(id_valid), 64'd0);

    // fill to full
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_instr = 32'h00000013;
    for (int i = 0; i < 4; i++) begin
      if_pc = 64'(i * 4);
      step();
      chk("t2.hold_pc", id_pc, 64'h0);
    end
    chk("t2.if_ready", 64'(if_ready), 64'd0);
    chk("t2.count", 64'(count), 64'd4);
    if_pc = 64'h10;
    step();
    chk("t2.ovf_count", 64'(count), 64'd4);
    chk("t2.ovf_head", id_pc, 64'h0);

    // full with push and pop together
    id_ready = 1'b1;
    #1;
    chk("t3.no_comb_ready", 64'(if_ready), 64'd0);
    step();
    chk("t3.count", 64'(count), 64'd3);
    chk("t3.if_ready", 64'(if_ready), 64'd1);
    chk("t3.head", id_pc, 64'h4);

    if_valid = 1'b0;
    repeat (3) step();
    chk("drain.count", 64'(count), 64'd0);

    // streaming with pointer wrap
    if_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if_pc = 64'(i * 4);
      step();
      chk("t4.pc", id_pc, 64'(i * 4));
      chk("t4.count", 64'(count), 64'd1);
    end
    if_valid = 1'b0;
    step();
    chk("t4.end_count", 64'(count), 64'd0);

    // flush with concurrent push and pop
    id_ready = 1'b0;
    if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_pc = 64'hA0 + 64'(i * 4);
      step();
    end
    chk("t5.pre_count", 64'(count), 64'd3);
    flush    = 1'b1;
    id_ready = 1'b1;
    if_pc    = 64'hBC;
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    chk("t5.count", 64'(count), 64'd0);
    chk("t5.valid", 64'(id_valid), 64'd0);
    chk("t5.instr", 64'(id_instr), 64'd0);
    chk("t5.pc", id_pc, 64'd0);
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_pc    = 64'hC0;
    step();
    if_valid = 1'b0;
    chk("t5.next_head", id_pc, 64'hC0);
    chk("t5.next_count", 64'(count), 64'd1);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;

    // compressed encoding, then reset mid-stream
    if_valid = 1'b1;
    if_pc    = 64'hD0;
    if_instr = 32'h00004501;
    step();
    chk("t6.illegal", 64'(id_illegal), 64'd1);
    chk("t6.instr", 64'(id_instr), 64'h00004501);
    if_pc    = 64'hD4;
    if_instr = 32'h00000013;
    step();
    chk("t6.count", 64'(count), 64'd2);
    chk("t6.hold_illegal", 64'(id_illegal), 64'd1);
    rst      = 1'b1;
    id_ready = 1'b1;
    step();
    rst      = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    chk_reset("t6.rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
